// File: rtl/seq_reader_if.sv
// RAM read port and output word stream of the sequential reader.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif

interface seq_reader_if #(
    parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = 32
);
    logic                     mem_req;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_ack;
    logic [DATA_WIDTH-1:0]    mem_data;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output mem_req, mem_addr, out_data, out_valid,
        input  mem_ack, mem_data, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_data, out_valid,
        output mem_ack, mem_data, out_ready
    );
endinterface

// File: rtl/seq_reader.sv
// Sequential RAM reader: fetches word_count words from base_addr
// one request at a time and streams them out through a small FWFT FIFO.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif

module seq_reader #(
    parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH-1:0] word_count,
    output logic                     busy,
    output logic                     done,
    seq_reader_if.master             bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              count;
    logic                     req;
    logic                     push;
    logic                     pop;
    logic                     load;
    logic                     last;
    logic                     done_nxt;

    assign last = (remaining == ADDRESS_WIDTH'(1));
    assign load = (state == IDLE) && start && (word_count != '0);

    // Space is reserved at issue time, so the later push cannot overflow.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        req       = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) state_nxt = ISSUE;
                    else                  done_nxt  = 1'b1;
                end
            end
            ISSUE: begin
                req = (count < (PW+1)'(FIFO_DEPTH));
                if (req) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    push      = 1'b1;
                    state_nxt = last ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base_addr;
            remaining <= word_count;
        end else if (push) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.mem_data;
    end

    assign pop           = bus.out_valid && bus.out_ready;
    assign busy          = (state != IDLE);
    assign bus.mem_req   = req;
    assign bus.mem_addr  = addr;
    assign bus.out_valid = (count != '0);
    // Gated so the stream reads as zero while the FIFO is empty.
    assign bus.out_data  = bus.out_valid ? fifo[rd_ptr] : '0;
endmodule

// File: tb/tb_seq_reader.sv
// Randomized scoreboard bench for seq_reader; the model expands each
// accepted start into its address and word sequence.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif

module tb_seq_reader;
    localparam int AW    = `ADDRESS_WIDTH;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic          busy;
    logic          done;

    seq_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    seq_reader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int exp_done = 0;
    int done_seen = 0;
    int ready_mode = 0;
    int max_delay = 2;
    int acks_left = -1;
    bit stale = 1'b0;
    int n_req = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + DW'(a);
    endfunction

    // RAM: single outstanding read, ack 1..max_delay+1 cycles after req
    initial begin
        bit pending;
        int delay;
        logic [AW-1:0] paddr;
        pending = 1'b0;
        delay = 0;
        paddr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (reset) begin
                pending = 1'b0;
                continue;
            end
            if (stale) begin
                stale = 1'b0;
                bus.mem_ack = 1'b1;
                bus.mem_data = 32'hDEAD_BEEF;
                continue;
            end
            if (pending) begin
                chk("single_outstanding", bus.mem_req, 1'b0);
                chk("addr_stable", bus.mem_addr, paddr);
                if (delay > 0) delay--;
                else if (acks_left != 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_data = ram_word(paddr);
                    pending = 1'b0;
                    if (acks_left > 0) acks_left--;
                end
            end else if (bus.mem_req) begin
                n_req++;
                paddr = bus.mem_addr;
                pending = 1'b1;
                delay = $urandom_range(max_delay, 0);
                chk("req_expected", exp_addr_q.size() != 0, 1'b1);
                if (exp_addr_q.size() != 0)
                    chk("req_addr", bus.mem_addr, exp_addr_q.pop_front());
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(1, 0));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted word
    initial begin
        logic prev_done;
        logic prev_stall;
        logic [DW-1:0] prev_data;
        prev_done = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_done = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) chk("hold_data", bus.out_data, prev_data);
            if (bus.out_valid && bus.out_ready) begin
                chk("pop_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    chk("out_data", bus.out_data, exp_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (done) begin
                done_seen++;
                chk("done_single", prev_done, 1'b0);
                chk("busy_at_done", busy, 1'b0);
                chk("done_drained", exp_q.size(), 0);
            end
            prev_done = done;
        end
    end

    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] wc,
                          input bit accepted, input bit completes);
        logic [AW-1:0] a;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        word_count = wc;
        if (accepted) begin
            if (completes) exp_done++;
            for (int i = 0; i < int'(wc); i++) begin
                a = b + AW'(i);
                exp_addr_q.push_back(a);
                exp_q.push_back(ram_word(a));
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_seen < exp_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", done_seen, exp_done);
        @(negedge clk);
        #3;
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] wc);
        launch(b, wc, 1'b1, 1'b1);
        #2;
        chk("busy_e1", busy, wc != '0);
        chk("req_e1", bus.mem_req, wc != '0);
        if (wc != '0) chk("addr_e1", bus.mem_addr, b);
        else          chk("done_e1", done, 1'b1);
        wait_done();
    endtask

    initial begin
        logic [AW-1:0] b;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Basic transfer, zero-wait RAM
        max_delay = 0;
        ready_mode = 0;
        n_req = 0;
        run(AW'(16'h0010), AW'(3));
        chk("basic_reqs", n_req, 3);

        // Backpressure: FIFO fills, requests stop
        max_delay = 1;
        ready_mode = 2;
        n_req = 0;
        launch(AW'($urandom), AW'(8), 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        #2;
        chk("bp_req_count", n_req, 4);
        chk("bp_req_idle", bus.mem_req, 1'b0);
        chk("bp_full", bus.out_valid, 1'b1);
        ready_mode = 0;
        wait_done();
        chk("bp_total_req", n_req, 8);

        // Zero length
        n_req = 0;
        run(AW'($urandom), '0);
        chk("zero_no_req", n_req, 0);

        // Address wrap
        b = '1;
        b = b - 1'b1;
        max_delay = 2;
        ready_mode = 1;
        run(b, AW'(4));

        // Ignored start while busy
        b = AW'($urandom);
        launch(b, AW'(6), 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        chk("busy_before_ignored", busy, 1'b1);
        launch(b ^ AW'(16'h5555), AW'(5), 1'b0, 1'b0);
        wait_done();

        // Reset while WAIT with two words buffered
        ready_mode = 2;
        max_delay = 0;
        acks_left = 2;
        n_req = 0;
        launch(AW'($urandom), AW'(8), 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        chk("pre_rst_reqs", n_req, 3);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        #2;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        acks_left = -1;
        @(negedge clk);
        stale = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #2;
            chk("stale_valid", bus.out_valid, 1'b0);
            chk("stale_busy", busy, 1'b0);
            chk("stale_done", done, 1'b0);
        end
        chk("rst_done_count", done_seen, exp_done);
        ready_mode = 1;
        run(AW'($urandom), AW'(5));

        // Randomized transfers
        for (int t = 0; t < 10; t++) begin
            max_delay = $urandom_range(2, 0);
            ready_mode = $urandom_range(1, 0);
            run(AW'($urandom), AW'($urandom_range(12, 1)));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
